// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered late results,
// with WAW squash and forced drain. Define WB_PERF_CNT_EN to add stall/kill counters.
module wb_port_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_wr_en,
    input  logic [2:0]  pipe_wr_reg,
    input  logic [15:0] pipe_wr_data,
    input  logic        late_valid,
    input  logic [2:0]  late_reg,
    input  logic [15:0] late_data,
    output logic        late_ready,
    output logic        pipe_stall,
    output logic        rf_wr_en,
    output logic [2:0]  rf_wr_reg,
    output logic [15:0] rf_wr_data,
    output logic        busy
`ifdef WB_PERF_CNT_EN
    ,
    output logic [15:0] stall_cycles,
    output logic [15:0] kill_count
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] WAIT_SAT = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        STARVE
    } state_t;

    state_t           state_q, state_d;
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             rf_wr_en_q, rf_wr_en_d;
    logic [2:0]       rf_wr_reg_q, rf_wr_reg_d;
    logic [15:0]      rf_wr_data_q, rf_wr_data_d;

    logic [2:0]       ent_reg_q  [DEPTH];
    logic [15:0]      ent_data_q [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;

    logic [PTR_W-1:0] wr_idx, rd_idx;
    logic             empty, full, push, pop;
    logic             head_live, pipe_grant, head_write, push_killed, starve_hit;

    assign wr_idx    = wr_ptr_q[PTR_W-1:0];
    assign rd_idx    = rd_ptr_q[PTR_W-1:0];
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (wr_idx == rd_idx);
    assign head_live = !empty && live_q[rd_idx];
    assign push      = late_valid && !full;

    // Port arbitration; a dead head is discarded without consuming the port.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        pipe_grant = 1'b0;
        head_write = 1'b0;
        pop        = 1'b0;
        if (state_q == STARVE) begin
            pop        = !empty;
            head_write = head_live;
        end else begin
            pipe_grant = pipe_wr_en;
            head_write = head_live && !pipe_wr_en;
            pop        = !empty && (!head_live || !pipe_wr_en);
        end
    end

    assign push_killed = pipe_grant && (late_reg == pipe_wr_reg);
    assign starve_hit  = (state_q == PEND) && head_live && pipe_grant && (wait_q == WAIT_SAT);

    always_comb begin
        live_d = live_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (pipe_grant && (ent_reg_q[i] == pipe_wr_reg)) begin
                live_d[i] = 1'b0;
            end
        end
        if (push) begin
            live_d[wr_idx] = !push_killed;
        end
        wr_ptr_d = wr_ptr_q + (PTR_W+1)'(push);
        rd_ptr_d = rd_ptr_q + (PTR_W+1)'(pop);
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        if (pop || (state_q == IDLE)) begin
            wait_d = '0;
        end else if (head_live && !head_write && (wait_q != WAIT_SAT)) begin
            wait_d = wait_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (push) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                if (starve_hit) begin
                    state_d = STARVE;
                end else if (wr_ptr_d == rd_ptr_d) begin
                    state_d = IDLE;
                end
            end
            STARVE: begin
                state_d = (wr_ptr_d == rd_ptr_d) ? IDLE : PEND;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rf_wr_en_d   = pipe_grant || head_write;
        rf_wr_reg_d  = rf_wr_reg_q;
        rf_wr_data_d = rf_wr_data_q;
        if (pipe_grant) begin
            rf_wr_reg_d  = pipe_wr_reg;
            rf_wr_data_d = pipe_wr_data;
        end else if (head_write) begin
            rf_wr_reg_d  = ent_reg_q[rd_idx];
            rf_wr_data_d = ent_data_q[rd_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            wait_q       <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_wr_reg_q  <= '0;
            rf_wr_data_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            wait_q       <= wait_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_wr_reg_q  <= rf_wr_reg_d;
            rf_wr_data_q <= rf_wr_data_d;
        end
    end

    // NOTE: entry storage is deliberately not reset; the pointers alone define which slots are valid.
    always_ff @(posedge clk) begin
        live_q <= live_d;
        if (push) begin
            ent_reg_q[wr_idx]  <= late_reg;
            ent_data_q[wr_idx] <= late_data;
        end
    end

    assign late_ready = !full;
    assign pipe_stall = (state_q == STARVE);
    assign busy       = !empty;
    assign rf_wr_en   = rf_wr_en_q;
    assign rf_wr_reg  = rf_wr_reg_q;
    assign rf_wr_data = rf_wr_data_q;

`ifdef WB_PERF_CNT_EN
    logic [15:0]      stall_cycles_q, stall_cycles_d;
    logic [15:0]      kill_count_q, kill_count_d;
    logic [PTR_W+1:0] kill_num;
    logic [PTR_W-1:0] slot_off;
    logic [PTR_W:0]   occupancy;
    logic [16:0]      kill_sum;

    assign occupancy = wr_ptr_q - rd_ptr_q;

    // Only valid, still-live entries count as kills; already-dead ones are not re-counted.
    always_comb begin
        kill_num = (PTR_W+2)'(push && push_killed);
        slot_off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off = PTR_W'(i) - rd_idx;
            if (pipe_grant && live_q[i] && (ent_reg_q[i] == pipe_wr_reg)
                && ({1'b0, slot_off} < occupancy)) begin
                kill_num = kill_num + (PTR_W+2)'(1);
            end
        end
        kill_sum       = {1'b0, kill_count_q} + 17'(kill_num);
        kill_count_d   = kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
        stall_cycles_d = stall_cycles_q;
        if (pipe_stall && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            kill_count_q   <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            kill_count_q   <= kill_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign kill_count   = kill_count_q;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_wb_port_arbiter;

    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_wr_en;
    logic [2:0]  pipe_wr_reg;
    logic [15:0] pipe_wr_data;
    logic        late_valid;
    logic [2:0]  late_reg;
    logic [15:0] late_data;
    logic        late_ready;
    logic        pipe_stall;
    logic        rf_wr_en;
    logic [2:0]  rf_wr_reg;
    logic [15:0] rf_wr_data;
    logic        busy;
`ifdef WB_PERF_CNT_EN
    logic [15:0] stall_cycles;
    logic [15:0] kill_count;
`endif

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .DEPTH   (DEPTH),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pipe_wr_en  (pipe_wr_en),
        .pipe_wr_reg (pipe_wr_reg),
        .pipe_wr_data(pipe_wr_data),
        .late_valid  (late_valid),
        .late_reg    (late_reg),
        .late_data   (late_data),
        .late_ready  (late_ready),
        .pipe_stall  (pipe_stall),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_reg   (rf_wr_reg),
        .rf_wr_data  (rf_wr_data),
        .busy        (busy)
`ifdef WB_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles),
        .kill_count  (kill_count)
`endif
    );

    typedef struct {
        logic [2:0]  r;
        logic [15:0] d;
        bit          live;
    } entry_t;

    // Reference model: pending late results in arrival order, plus starvation bookkeeping.
    entry_t      q[$];
    bit          m_forced;
    int          m_lost;
    bit          exp_en;
    logic [2:0]  exp_reg;
    logic [15:0] exp_data;
    int          m_stalls;
    int          m_kills;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_forced = 1'b0;
        m_lost   = 0;
        exp_en   = 1'b0;
        exp_reg  = '0;
        exp_data = '0;
        m_stalls = 0;
        m_kills  = 0;
    endtask

    // One clock cycle: drive, check outputs against the model, advance the model.
    task automatic step(input bit pe, input logic [2:0] pr, input logic [15:0] pd,
                        input bit lv, input logic [2:0] lr, input logic [15:0] ld);
        bit          grant_pipe;
        bit          accept;
        bit          wrote;
        logic [2:0]  wr;
        logic [15:0] wd;
        pipe_wr_en   = pe;
        pipe_wr_reg  = pr;
        pipe_wr_data = pd;
        late_valid   = lv;
        late_reg     = lr;
        late_data    = ld;
        #2;
        check("pipe_stall", 32'(pipe_stall), 32'(m_forced));
        check("late_ready", 32'(late_ready), 32'(q.size() < DEPTH));
        check("busy",       32'(busy),       32'(q.size() != 0));
        check("rf_wr_en",   32'(rf_wr_en),   32'(exp_en));
        check("rf_wr_reg",  32'(rf_wr_reg),  32'(exp_reg));
        check("rf_wr_data", 32'(rf_wr_data), 32'(exp_data));
`ifdef WB_PERF_CNT_EN
        check("stall_cycles", 32'(stall_cycles), 32'(m_stalls));
        check("kill_count",   32'(kill_count),   32'(m_kills));
        if (m_forced) m_stalls++;
`endif

        grant_pipe = !m_forced && pe;
        accept     = lv && (q.size() < DEPTH);
        wrote      = 1'b0;
        wr         = '0;
        wd         = '0;
        if (q.size() > 0) begin
            if (m_forced || !q[0].live || !pe) begin
                wrote = q[0].live && !grant_pipe;
                wr    = q[0].r;
                wd    = q[0].d;
                void'(q.pop_front());
                m_lost   = 0;
                m_forced = 1'b0;
            end else if (m_lost == MAX_WAIT - 1) begin
                m_forced = 1'b1;
            end else begin
                m_lost++;
            end
        end
        if (grant_pipe) begin
            foreach (q[i]) begin
                if (q[i].r == pr) begin
                    if (q[i].live) m_kills++;
                    q[i].live = 1'b0;
                end
            end
        end
        if (accept) begin
            if (grant_pipe && (lr == pr)) m_kills++;
            q.push_back('{lr, ld, !(grant_pipe && (lr == pr))});
        end
        exp_en = grant_pipe || wrote;
        if (grant_pipe) begin
            exp_reg  = pr;
            exp_data = pd;
        end else if (wrote) begin
            exp_reg  = wr;
            exp_data = wd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          pe;
        logic [2:0]  pr;
        logic [15:0] pd;

        // Reset while a late result is being offered.
        rst_n        = 1'b0;
        pipe_wr_en   = 1'b0;
        pipe_wr_reg  = '0;
        pipe_wr_data = '0;
        late_valid   = 1'b1;
        late_reg     = 3'd1;
        late_data    = 16'hA5A5;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_rf_wr_en",   32'(rf_wr_en),   32'd0);
        check("rst_rf_wr_reg",  32'(rf_wr_reg),  32'd0);
        check("rst_rf_wr_data", 32'(rf_wr_data), 32'd0);
        check("rst_pipe_stall", 32'(pipe_stall), 32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_late_ready", 32'(late_ready), 32'd1);
        rst_n = 1'b1;

        // First push right after reset: written two cycles later.
        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd1, 16'hA5A5);
        idle();
        check("post_rst_en",   32'(rf_wr_en),   32'd1);
        check("post_rst_reg",  32'(rf_wr_reg),  32'd1);
        check("post_rst_data", 32'(rf_wr_data), 32'hA5A5);
        idle();

        // Simultaneous pipeline and late request: pipeline first.
        step(1'b1, 3'd3, 16'h1234, 1'b1, 3'd5, 16'hBEEF);
        check("both_pipe_reg",  32'(rf_wr_reg),  32'd3);
        check("both_pipe_data", 32'(rf_wr_data), 32'h1234);
        check("both_busy",      32'(busy),       32'd1);
        idle();
        check("both_late_en",   32'(rf_wr_en),   32'd1);
        check("both_late_reg",  32'(rf_wr_reg),  32'd5);
        check("both_late_data", 32'(rf_wr_data), 32'hBEEF);
        check("both_busy_done", 32'(busy),       32'd0);
        idle();

        // WAW: younger pipeline write to R2 squashes the buffered late R2.
        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 16'h5555);
        step(1'b1, 3'd2, 16'h0007, 1'b0, 3'd0, 16'h0);
        check("waw_en",   32'(rf_wr_en),   32'd1);
        check("waw_reg",  32'(rf_wr_reg),  32'd2);
        check("waw_data", 32'(rf_wr_data), 32'h0007);
        idle();
        check("waw_silent_en",   32'(rf_wr_en),   32'd0);
        check("waw_silent_data", 32'(rf_wr_data), 32'h0007);
        check("waw_busy",        32'(busy),       32'd0);
        idle();

        // Starvation: pipeline wins MAX_WAIT cycles, then a single stall cycle.
        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 16'h4444);
        for (int k = 1; k <= MAX_WAIT; k++) begin
            step(1'b1, 3'd6, 16'h6000, 1'b0, 3'd0, 16'h0);
            check($sformatf("starve_stall_%0d", k), 32'(pipe_stall), 32'(k == MAX_WAIT));
        end
        step(1'b1, 3'd6, 16'h6000, 1'b0, 3'd0, 16'h0);
        check("starve_stall_end", 32'(pipe_stall), 32'd0);
        check("starve_late_reg",  32'(rf_wr_reg),  32'd4);
        check("starve_late_data", 32'(rf_wr_data), 32'h4444);
        step(1'b1, 3'd6, 16'h6000, 1'b0, 3'd0, 16'h0);
        check("starve_pipe_reg",  32'(rf_wr_reg),  32'd6);
        idle();

        // Fill the FIFO while the pipeline holds the port.
        step(1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222);
        step(1'b1, 3'd1, 16'h1112, 1'b1, 3'd3, 16'h3333);
        check("full_ready", 32'(late_ready), 32'd0);
        step(1'b1, 3'd1, 16'h1113, 1'b1, 3'd4, 16'h4444);
        check("full_ready_hold", 32'(late_ready), 32'd0);
        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 16'h4444);
        check("full_pop_ready", 32'(late_ready), 32'd1);
        check("full_pop_reg",   32'(rf_wr_reg),  32'd2);
        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 16'h4444);
        check("full_pop2_data", 32'(rf_wr_data), 32'h3333);
        idle();
        check("full_third_reg",  32'(rf_wr_reg),  32'd4);
        check("full_third_data", 32'(rf_wr_data), 32'h4444);
        idle();

        // Asynchronous reset in the middle of a forced drain.
        step(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'h5A5A);
        step(1'b1, 3'd7, 16'h7000, 1'b1, 3'd6, 16'h6A6A);
        for (int k = 2; k <= MAX_WAIT; k++) begin
            step(1'b1, 3'd7, 16'h7000, 1'b0, 3'd0, 16'h0);
        end
        check("mid_starve_stall", 32'(pipe_stall), 32'd1);
        check("mid_starve_en",    32'(rf_wr_en),   32'd1);
        pipe_wr_en = 1'b0;
        late_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_stall", 32'(pipe_stall), 32'd0);
        check("async_rst_en",    32'(rf_wr_en),   32'd0);
        check("async_rst_busy",  32'(busy),       32'd0);
        check("async_rst_ready", 32'(late_ready), 32'd1);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) idle();

        // Random traffic; pipeline inputs are held while the pipeline is stalled.
        pe = 1'b0;
        pr = '0;
        pd = '0;
        for (int n = 0; n < 600; n++) begin
            if (!m_forced) begin
                pe = ($urandom_range(0, 99) < 55);
                pr = 3'($urandom_range(0, 3));
                pd = 16'($urandom);
            end
            step(pe, pr, pd, ($urandom_range(0, 99) < 50),
                 3'($urandom_range(0, 3)), 16'($urandom));
        end
        repeat (8) idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Owns the single register-file write port fed by the writeback stage.
- Shares that port between two requesters:
  - the in-order pipeline writeback result (ALU / memory / JAL PC_Next already selected upstream);
  - a late-returning result source (multi-cycle stalling memory, future multi-cycle unit).
- Buffers late results in a small FIFO.
- Squashes stale late writes (WAW) and forces a pipeline stall when a late result has waited too long.

Parameters:
- DEPTH, 2, late-result FIFO entries (power of two, >=2).
- MAX_WAIT, 4, consecutive lost arbitration cycles before the head entry forces a stall (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- pipe_wr_en  in  1  pipeline writeback requests a register write this cycle.
- pipe_wr_reg  in  3  destination register of pipeline write.
- pipe_wr_data  in  16  pipeline writeback data.
- late_valid  in  1  late result offered.
- late_reg  in  3  late result destination register.
- late_data  in  16  late result data.
- late_ready  out  1  FIFO can accept; equals !full.
- pipe_stall  out  1  pipeline must freeze writeback and hold pipe_wr_* stable.
- rf_wr_en  out  1  register-file write enable (registered).
- rf_wr_reg  out  3  register-file write address (registered).
- rf_wr_data  out  16  register-file write data (registered).
- busy  out  1  FIFO non-empty.

Behaviour:
- FIFO entry = {reg[2:0], data[15:0], live}.
  - Push when late_valid & late_ready; pushed entry has live=1 unless killed the same cycle.
  - At most one push and one pop per cycle.
- States: IDLE (FIFO empty), PEND (non-empty, pipeline priority), STARVE (forced drain).
  - IDLE->PEND on push.
  - PEND->IDLE when the last entry pops with no push.
  - PEND->STARVE when the wait counter reaches MAX_WAIT-1 and the live head loses arbitration again.
  - STARVE->PEND after the head pops if the FIFO is still non-empty, else ->IDLE.
- Grant rules in IDLE/PEND:
  - pipe_wr_en=1 -> grant pipeline.
  - Else, live head -> grant head and pop it.
  - A dead head (live=0) pops without using the port, even in the same cycle as a pipeline grant.
- STARVE:
  - pipe_stall=1 (combinational from state).
  - pipe_wr_en ignored.
  - Head granted and popped. A dead head pops with no write, then the block leaves STARVE.
- Wait counter:
  - Increments each cycle a live head exists and is not granted.
  - Clears on any head pop and in IDLE.
  - Saturates at MAX_WAIT-1.
- WAW kill (late results always belong to instructions older than the one at writeback):
  - When a pipeline write to register R is granted, every FIFO entry with reg==R is cleared to live=0.
  - A same-cycle push to R is also cleared.
- Output timing:
  - The grant in cycle N produces rf_wr_en=1, rf_wr_reg, rf_wr_data in cycle N+1.
  - rf_wr_en=0 in cycles with no grant; rf_wr_reg/rf_wr_data hold their last value.
- Full: late_ready=0 while full, including cycles that also pop (no same-cycle push-on-pop).
- Reset (any time, async):
  - rf_wr_en=0, rf_wr_reg=0, rf_wr_data=0.
  - pipe_stall=0, busy=0, late_ready=1.
  - State IDLE, counter 0, FIFO pointers 0 (entries discarded).

Optional Feature:
- WB_PERF_CNT_EN defined: adds outputs stall_cycles[15:0] and kill_count[15:0].
  - stall_cycles increments each cycle pipe_stall=1.
  - kill_count increments per entry killed by WAW (simultaneous kills counted individually).
  - Both saturate at 16'hFFFF and reset to 0.
- Not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset with late_valid=1 held -> all outputs 0, late_ready=1. Release -> push accepted in the first cycle; rf_wr_en=1, reg/data match, two cycles after the push (pop next cycle, output the cycle after).
- pipe_wr_en=1 R3=16'h1234 and late_valid=1 R5=16'hBEEF in the same cycle:
  - next cycle: rf_wr R3/1234;
  - following cycle (pipe idle): rf_wr R5/BEEF;
  - busy then returns to 0.
- Late R2 pushed, then pipe_wr_en R2=16'h0007 granted -> entry killed, pops silently; rf_wr_en=1 once only, for R2/0007.
- MAX_WAIT=4, one live entry, pipe_wr_en held 1 -> pipeline wins 4 cycles, then pipe_stall=1 for exactly one cycle. Late write appears on the next cycle; pipe data is not written during the stall.
- Fill FIFO (DEPTH=2) with pipe busy -> late_ready=0. A third late_valid is not accepted until a pop completes.
- Assert rst_n low mid-STARVE -> pipe_stall and rf_wr_en drop immediately; buffered entries are never written.
